ram_port_arbiter: RTL and testbench

- Shares the single CPU-side port of the 48K system RAM between the Z80 bus and the ESP32 SPI loader.
- Replaces the hard mux selected by the CPU-halt control bit: SPI accesses are slotted between CPU accesses, and the CPU is stalled via wait_n only on real contention.
- A hold input still grants SPI exclusive use of the port.
- Also enforces write protection of the ROM region against CPU writes.

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/spi_req_buffer.sv | 81 ++++++++
 rtl/ram_port_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter: FSM state encoding,
// default ROM boundary and the starvation counter width.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCpuAcc,
        StSpiAcc
    } arb_state_e;

    localparam logic [15:0] RomTopDefault = 16'h3000;

    function automatic int unsigned starve_cnt_width(input int unsigned max_wait);
        return (max_wait == 0) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/spi_req_buffer.sv
// One-entry holding register for SPI loader requests. Presents either the latched
// request or the live one, and raises a sticky overflow flag when a request is dropped.
module spi_req_buffer #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_wr,
    input  logic              spi_rd,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_wdata,
    input  logic              grant,
    output logic              req_valid,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic              pend,
    output logic              spi_ovf
);

    logic              pend_q, pend_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ovf_q, ovf_d;
    logic              new_req;

    assign new_req   = spi_wr | spi_rd;
    assign req_valid = pend_q | new_req;
    assign req_we    = pend_q ? we_q : spi_wr;
    assign req_addr  = pend_q ? addr_q : spi_addr;
    assign req_wdata = pend_q ? wdata_q : spi_wdata;
    assign pend      = pend_q;
    assign spi_ovf   = ovf_q;

    always_comb begin
        pend_d  = pend_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ovf_d   = ovf_q;
        // Simultaneous write and read: write wins, read is lost.
        if (spi_wr && spi_rd) begin
            ovf_d = 1'b1;
        end
        if (pend_q) begin
            if (grant) begin
                // Slot frees at this edge, so a new arrival can take it.
                pend_d  = new_req;
                we_d    = spi_wr;
                addr_d  = spi_addr;
                wdata_d = spi_wdata;
            end else if (new_req) begin
                ovf_d = 1'b1;
            end
        end else if (new_req && !grant) begin
            pend_d  = 1'b1;
            we_d    = spi_wr;
            addr_d  = spi_addr;
            wdata_d = spi_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the CPU-side port of the 48K system RAM between the Z80 bus and the SPI
// loader, stalling the CPU only on contention and blocking CPU writes to ROM.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 16,
    parameter int unsigned       DATA_W       = 8,
    parameter logic [ADDR_W-1:0] ROM_TOP      = RomTopDefault,
    parameter int unsigned       SPI_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_wait_n,
    input  logic              spi_wr,
    input  logic              spi_rd,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_wdata,
    output logic [DATA_W-1:0] spi_rdata,
    output logic              spi_rvalid,
    output logic              spi_ovf,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int unsigned          StarveW   = starve_cnt_width(SPI_MAX_WAIT);
    localparam logic [StarveW-1:0]   StarveMax = StarveW'(SPI_MAX_WAIT);

    arb_state_e        state_q, state_d;
    logic              cpu_pend_q, cpu_pend_d;
    logic              cpu_we_q, cpu_we_d;
    logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
    logic [DATA_W-1:0] cpu_wdata_q, cpu_wdata_d;
    logic [StarveW-1:0] starve_q, starve_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              acc_we_q, acc_we_d;
    logic              cpu_ack_q, cpu_ack_rd_q, spi_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] spi_rdata_q, spi_rdata_d;

    logic              cpu_valid, cpu_sel_we;
    logic [ADDR_W-1:0] cpu_sel_addr;
    logic [DATA_W-1:0] cpu_sel_wdata;
    logic              spi_valid, spi_sel_we, spi_pend;
    logic [ADDR_W-1:0] spi_sel_addr;
    logic [DATA_W-1:0] spi_sel_wdata;
    logic              cpu_grant, spi_grant;

    spi_req_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_spi_buf (
        .clk       (clk),
        .reset     (reset),
        .spi_wr    (spi_wr),
        .spi_rd    (spi_rd),
        .spi_addr  (spi_addr),
        .spi_wdata (spi_wdata),
        .grant     (spi_grant),
        .req_valid (spi_valid),
        .req_we    (spi_sel_we),
        .req_addr  (spi_sel_addr),
        .req_wdata (spi_sel_wdata),
        .pend      (spi_pend),
        .spi_ovf   (spi_ovf)
    );

    // A latched CPU request masks any new cpu_req until it is granted.
    assign cpu_valid     = cpu_pend_q | cpu_req;
    assign cpu_sel_we    = cpu_pend_q ? cpu_we_q : cpu_we;
    assign cpu_sel_addr  = cpu_pend_q ? cpu_addr_q : cpu_addr;
    assign cpu_sel_wdata = cpu_pend_q ? cpu_wdata_q : cpu_wdata;

    always_comb begin
        state_d   = state_q;
        cpu_grant = 1'b0;
        spi_grant = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hold) begin
                    spi_grant = spi_valid;
                end else if (cpu_valid && spi_valid && (starve_q >= StarveMax)) begin
                    spi_grant = 1'b1;
                end else if (cpu_valid) begin
                    cpu_grant = 1'b1;
                end else begin
                    spi_grant = spi_valid;
                end
                if (cpu_grant) begin
                    state_d = StCpuAcc;
                end else if (spi_grant) begin
                    state_d = StSpiAcc;
                end
            end
            StCpuAcc, StSpiAcc: state_d = StIdle;
            default:            state_d = StIdle;
        endcase
    end

    always_comb begin
        cpu_pend_d  = cpu_pend_q;
        cpu_we_d    = cpu_we_q;
        cpu_addr_d  = cpu_addr_q;
        cpu_wdata_d = cpu_wdata_q;
        if (cpu_pend_q) begin
            if (cpu_grant) begin
                cpu_pend_d = 1'b0;
            end
        end else if (cpu_req && !cpu_grant) begin
            cpu_pend_d  = 1'b1;
            cpu_we_d    = cpu_we;
            cpu_addr_d  = cpu_addr;
            cpu_wdata_d = cpu_wdata;
        end

        starve_d = starve_q;
        if (spi_grant) begin
            starve_d = '0;
        end else if (spi_pend && (starve_q < StarveMax)) begin
            starve_d = starve_q + StarveW'(1);
        end

        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        acc_we_d   = acc_we_q;
        if (cpu_grant) begin
            // Protected writes still run the access cycle; only the strobe is suppressed.
            ram_we_d   = cpu_sel_we && (cpu_sel_addr >= ROM_TOP);
            ram_addr_d = cpu_sel_addr;
            ram_din_d  = cpu_sel_wdata;
            acc_we_d   = cpu_sel_we;
        end else if (spi_grant) begin
            ram_we_d   = spi_sel_we;
            ram_addr_d = spi_sel_addr;
            ram_din_d  = spi_sel_wdata;
            acc_we_d   = spi_sel_we;
        end

        // RAM data is valid in the ack cycle, so pass it straight through then.
        cpu_rdata_d = cpu_ack_rd_q ? ram_dout : cpu_rdata_q;
        spi_rdata_d = spi_rvalid_q ? ram_dout : spi_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cpu_pend_q   <= 1'b0;
            cpu_we_q     <= 1'b0;
            cpu_addr_q   <= '0;
            cpu_wdata_q  <= '0;
            starve_q     <= '0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            acc_we_q     <= 1'b0;
            cpu_ack_q    <= 1'b0;
            cpu_ack_rd_q <= 1'b0;
            spi_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            spi_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cpu_pend_q   <= cpu_pend_d;
            cpu_we_q     <= cpu_we_d;
            cpu_addr_q   <= cpu_addr_d;
            cpu_wdata_q  <= cpu_wdata_d;
            starve_q     <= starve_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            acc_we_q     <= acc_we_d;
            cpu_ack_q    <= (state_q == StCpuAcc);
            cpu_ack_rd_q <= (state_q == StCpuAcc) && !acc_we_q;
            spi_rvalid_q <= (state_q == StSpiAcc) && !acc_we_q;
            cpu_rdata_q  <= cpu_rdata_d;
            spi_rdata_q  <= spi_rdata_d;
        end
    end

    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;
    assign cpu_ack    = cpu_ack_q;
    assign cpu_rdata  = cpu_rdata_d;
    assign cpu_wait_n = !cpu_pend_q;
    assign spi_rvalid = spi_rvalid_q;
    assign spi_rdata  = spi_rdata_d;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural synchronous RAM behind the port.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_wait_n;
    logic        spi_wr, spi_rd;
    logic [15:0] spi_addr;
    logic [7:0]  spi_wdata, spi_rdata;
    logic        spi_rvalid, spi_ovf;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout = 8'h00;
    logic [7:0]  mem [0:65535];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    ram_port_arbiter #(
        .ADDR_W       (16),
        .DATA_W       (8),
        .ROM_TOP      (16'h3000),
        .SPI_MAX_WAIT (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hold       (hold),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .cpu_wait_n (cpu_wait_n),
        .spi_wr     (spi_wr),
        .spi_rd     (spi_rd),
        .spi_addr   (spi_addr),
        .spi_wdata  (spi_wdata),
        .spi_rdata  (spi_rdata),
        .spi_rvalid (spi_rvalid),
        .spi_ovf    (spi_ovf),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0;
        spi_wr  = 1'b0;
        spi_rd  = 1'b0;
    endtask

    task automatic cpu_issue(input logic we, input logic [15:0] a, input logic [7:0] d);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    task automatic spi_issue(input logic wr, input logic [15:0] a, input logic [7:0] d);
        spi_wr    = wr;
        spi_rd    = !wr;
        spi_addr  = a;
        spi_wdata = d;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_ram_we"},     ram_we,     1'b0);
        chk({pfx, "_ram_addr"},   ram_addr,   16'h0000);
        chk({pfx, "_ram_din"},    ram_din,    8'h00);
        chk({pfx, "_cpu_ack"},    cpu_ack,    1'b0);
        chk({pfx, "_cpu_rdata"},  cpu_rdata,  8'h00);
        chk({pfx, "_cpu_wait_n"}, cpu_wait_n, 1'b1);
        chk({pfx, "_spi_rdata"},  spi_rdata,  8'h00);
        chk({pfx, "_spi_rvalid"}, spi_rvalid, 1'b0);
        chk({pfx, "_spi_ovf"},    spi_ovf,    1'b0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h4000] = 8'hA5;
        mem[16'h6000] = 8'hC3;
        reset = 1'b1;
        hold = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = 16'h0000;
        cpu_wdata = 8'h00;
        spi_addr = 16'h0000;
        spi_wdata = 8'h00;
        idle_inputs();

        // Reset state
        tick();
        tick();
        chk_reset_outputs("rst");
        reset = 1'b0;
        tick();

        // Uncontended CPU read of 0x4000
        cpu_issue(1'b0, 16'h4000, 8'h00);
        tick();
        idle_inputs();
        chk("rd_t1_addr", ram_addr, 16'h4000);
        chk("rd_t1_we", ram_we, 1'b0);
        chk("rd_t1_ack", cpu_ack, 1'b0);
        chk("rd_t1_wait", cpu_wait_n, 1'b1);
        tick();
        chk("rd_t2_ack", cpu_ack, 1'b1);
        chk("rd_t2_rdata", cpu_rdata, 8'hA5);
        chk("rd_t2_wait", cpu_wait_n, 1'b1);
        tick();
        chk("rd_t3_ack", cpu_ack, 1'b0);
        chk("rd_t3_hold", cpu_rdata, 8'hA5);

        // Protected write, then unprotected write at the boundary, then readback
        cpu_issue(1'b1, 16'h0100, 8'h55);
        tick();
        idle_inputs();
        chk("wp_we", ram_we, 1'b0);
        chk("wp_addr", ram_addr, 16'h0100);
        tick();
        chk("wp_ack", cpu_ack, 1'b1);
        chk("wp_rdata_hold", cpu_rdata, 8'hA5);
        cpu_issue(1'b1, 16'h3000, 8'h66);
        tick();
        idle_inputs();
        chk("wr_we", ram_we, 1'b1);
        chk("wr_addr", ram_addr, 16'h3000);
        chk("wr_din", ram_din, 8'h66);
        tick();
        chk("wr_ack", cpu_ack, 1'b1);
        chk("wp_mem", mem[16'h0100], 8'h00);
        chk("wr_mem", mem[16'h3000], 8'h66);
        cpu_issue(1'b0, 16'h3000, 8'h00);
        tick();
        idle_inputs();
        tick();
        chk("rb_ack", cpu_ack, 1'b1);
        chk("rb_rdata", cpu_rdata, 8'h66);

        // CPU and SPI write in the same cycle: CPU first, SPI two cycles later
        cpu_issue(1'b0, 16'h4000, 8'h00);
        spi_issue(1'b1, 16'h5000, 8'h11);
        tick();
        idle_inputs();
        chk("co_t1_addr", ram_addr, 16'h4000);
        chk("co_t1_we", ram_we, 1'b0);
        chk("co_t1_wait", cpu_wait_n, 1'b1);
        tick();
        chk("co_t2_ack", cpu_ack, 1'b1);
        chk("co_t2_wait", cpu_wait_n, 1'b1);
        tick();
        chk("co_t3_we", ram_we, 1'b1);
        chk("co_t3_addr", ram_addr, 16'h5000);
        chk("co_t3_din", ram_din, 8'h11);
        chk("co_t3_wait", cpu_wait_n, 1'b1);
        tick();
        chk("co_t4_rvalid", spi_rvalid, 1'b0);
        chk("co_mem", mem[16'h5000], 8'h11);

        // Starvation: SPI read pending against CPU requests every 2 cycles
        for (int c = 0; c <= 14; c++) begin
            if (c == 0) spi_issue(1'b0, 16'h6000, 8'h00);
            if ((c % 2 == 0) && (c <= 10)) cpu_issue(1'b0, 16'h4000, 8'h00);
            tick();
            idle_inputs();
            chk($sformatf("sv_c%0d_rvalid", c + 1), spi_rvalid, (c + 1 == 12));
            chk($sformatf("sv_c%0d_wait", c + 1), cpu_wait_n,
                !((c + 1 == 11) || (c + 1 == 12)));
            chk($sformatf("sv_c%0d_ack", c + 1), cpu_ack,
                ((c + 1) % 2 == 0) && ((c + 1 <= 10) || (c + 1 == 14)));
            if (c + 1 == 12) chk("sv_spi_rdata", spi_rdata, 8'hC3);
        end

        // Hold: CPU stays stalled while SPI writes go through
        hold = 1'b1;
        cpu_issue(1'b0, 16'h4000, 8'h00);
        tick();
        idle_inputs();
        chk("hd_h1_wait", cpu_wait_n, 1'b0);
        spi_issue(1'b1, 16'h5100, 8'h22);
        tick();
        idle_inputs();
        chk("hd_h2_we", ram_we, 1'b1);
        chk("hd_h2_addr", ram_addr, 16'h5100);
        chk("hd_h2_wait", cpu_wait_n, 1'b0);
        tick();
        spi_issue(1'b1, 16'h5101, 8'h23);
        tick();
        idle_inputs();
        chk("hd_h4_addr", ram_addr, 16'h5101);
        chk("hd_h4_din", ram_din, 8'h23);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("hd_wait_%0d", k), cpu_wait_n, 1'b0);
            chk($sformatf("hd_ack_%0d", k), cpu_ack, 1'b0);
        end
        chk("hd_mem", mem[16'h5100], 8'h22);
        hold = 1'b0;
        tick();
        chk("hd_rel_wait", cpu_wait_n, 1'b1);
        chk("hd_rel_addr", ram_addr, 16'h4000);
        tick();
        chk("hd_rel_ack", cpu_ack, 1'b1);
        chk("hd_rel_rdata", cpu_rdata, 8'hA5);

        // Overflow: second SPI write while one is pending is dropped
        cpu_issue(1'b0, 16'h4000, 8'h00);
        spi_issue(1'b1, 16'h5200, 8'h33);
        tick();
        idle_inputs();
        chk("ov_o1_ovf", spi_ovf, 1'b0);
        spi_issue(1'b1, 16'h5201, 8'h44);
        tick();
        idle_inputs();
        chk("ov_o2_ovf", spi_ovf, 1'b1);
        tick();
        chk("ov_o3_we", ram_we, 1'b1);
        chk("ov_o3_addr", ram_addr, 16'h5200);
        chk("ov_o3_din", ram_din, 8'h33);
        tick();
        chk("ov_mem_kept", mem[16'h5200], 8'h33);
        chk("ov_mem_lost", mem[16'h5201], 8'h00);
        chk("ov_sticky", spi_ovf, 1'b1);

        // Reset during SPI_ACC of a read
        spi_issue(1'b0, 16'h6000, 8'h00);
        tick();
        idle_inputs();
        chk("mr_acc_addr", ram_addr, 16'h6000);
        reset = 1'b1;
        tick();
        chk_reset_outputs("mr");
        reset = 1'b0;
        tick();
        chk("mr_post_rvalid", spi_rvalid, 1'b0);
        chk("mr_post_rdata", spi_rdata, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
